// File: rtl/calc_pkg.sv
// Shared operator codes and sequencer state encoding for the calculator datapath.
// The keypad/entry logic imports this too, so operator codes stay consistent.
package calc_pkg;

    localparam int WIDTH_DEFAULT = 10;
    localparam int OP_W          = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NONE = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_MUL  = 4'd3,
        OP_DIV  = 4'd4,
        OP_NEG  = 4'd6
    } calc_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDSUB,
        S_ITER,
        S_FIX
    } calc_seq_state_t;

endpackage

// File: rtl/calc_alu_seq_if.sv
// Request/response bundle between the entry/display logic and the ALU sequencer.
interface calc_alu_seq_if
    import calc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             start;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err_div0;
    logic             err_ovf;
    logic             err_op;

    modport master (
        output start, op, a, b,
        input  busy, done, result, err_div0, err_ovf, err_op
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, err_div0, err_ovf, err_op
    );
endinterface

// File: rtl/calc_iter_core.sv
// Magnitude-only iteration registers: shift-add multiply (LSB of the multiplier
// first) and restoring divide (MSB of the dividend first), one bit per step.
// Multiply leaves the 2*WIDTH-bit product in {acc, shreg}; divide leaves the
// quotient in shreg and the remainder in acc.
module calc_iter_core
    import calc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,     // 0: multiply, 1: divide (sampled on load)
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] shreg
);
    logic             mode_q;
    logic [WIDTH-1:0] opnd_q;   // multiplicand or divisor
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             rem_ge;

    // One step of either algorithm; the subtraction fits WIDTH bits whenever it is used.
    always_comb begin
        mul_sum = {1'b0, acc} + (shreg[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = {acc, shreg[WIDTH-1]};
        rem_ge  = (rem_sh >= {1'b0, opnd_q});
        rem_sub = rem_sh[WIDTH-1:0] - opnd_q;
    end

    // Load operands, then advance one bit per step pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
            opnd_q <= '0;
            acc    <= '0;
            shreg  <= '0;
        end else if (load) begin
            mode_q <= mode;
            acc    <= '0;
            opnd_q <= mode ? b_mag : a_mag;
            shreg  <= mode ? a_mag : b_mag;
        end else if (step) begin
            if (mode_q) begin
                acc   <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
                shreg <= {shreg[WIDTH-2:0], rem_ge};
            end else begin
                acc   <= mul_sum[WIDTH:1];
                shreg <= {mul_sum[0], shreg[WIDTH-1:1]};
            end
        end
    end
endmodule

// File: rtl/calc_alu_seq.sv
// Multi-cycle ALU sequencer: add/sub in one step, mul/div iterate through
// calc_iter_core, then a FIX step applies the sign and overflow check.
module calc_alu_seq
    import calc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
)
(
    input  logic          clk,
    input  logic          rst,
    calc_alu_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int MW    = 2 * WIDTH;
    localparam logic [MW-1:0] POS_MAX = MW'((1 << (WIDTH - 1)) - 1);
    localparam logic [MW-1:0] NEG_MAG = MW'(1 << (WIDTH - 1));

    calc_seq_state_t  state_q, state_d;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sign_q;
    logic [CNT_W-1:0] cnt_q;

    logic             core_load, core_step, core_div, iter_op;
    logic [WIDTH-1:0] a_mag, b_mag, core_acc, core_shreg;
    logic [WIDTH-1:0] add_res, sub_res, fix_res;
    logic             add_ovf, sub_ovf, fix_ovf;
    logic [MW-1:0]    fix_mag;

    // -(-2^(WIDTH-1)) wraps to the same pattern, which is the correct unsigned magnitude.
    assign a_mag    = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign b_mag    = bus.b[WIDTH-1] ? -bus.b : bus.b;
    assign core_div = (bus.op == OP_DIV);
    assign iter_op  = (bus.op == OP_MUL) || (core_div && (bus.b != '0));

    calc_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst   (rst),
        .mode  (core_div),
        .load  (core_load),
        .step  (core_step),
        .a_mag (a_mag),
        .b_mag (b_mag),
        .acc   (core_acc),
        .shreg (core_shreg)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state and core control; counter value 0 is a dedicated exit cycle into FIX.
    always_comb begin
        state_d   = state_q;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (iter_op) begin
                        state_d   = S_ITER;
                        core_load = 1'b1;
                    end else begin
                        state_d   = S_ADDSUB;
                    end
                end
            end
            S_ADDSUB: state_d = S_IDLE;
            S_ITER: begin
                if (cnt_q != '0) core_step = 1'b1;
                else             state_d   = S_FIX;
            end
            S_FIX:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Single-step results from the latched raw operands.
    always_comb begin
        add_res = a_q + b_q;
        sub_res = a_q - b_q;
        add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_res[WIDTH-1] != a_q[WIDTH-1]);
        sub_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_res[WIDTH-1] != a_q[WIDTH-1]);
    end

    // Sign application and range check on the mul/div magnitude.
    always_comb begin
        if (op_q == OP_MUL) fix_mag = {core_acc, core_shreg};
        else                fix_mag = {{WIDTH{1'b0}}, core_shreg};
        fix_res = sign_q ? -fix_mag[WIDTH-1:0] : fix_mag[WIDTH-1:0];
        fix_ovf = sign_q ? (fix_mag > NEG_MAG) : (fix_mag > POS_MAX);
    end

    // Request latch, iteration counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sign_q       <= 1'b0;
            cnt_q        <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.result   <= '0;
            bus.err_div0 <= 1'b0;
            bus.err_ovf  <= 1'b0;
            bus.err_op   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q         <= bus.op;
                        a_q          <= bus.a;
                        b_q          <= bus.b;
                        sign_q       <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        cnt_q        <= CNT_W'(WIDTH);
                        bus.busy     <= 1'b1;
                        bus.err_div0 <= 1'b0;
                        bus.err_ovf  <= 1'b0;
                        bus.err_op   <= 1'b0;
                    end
                end
                S_ADDSUB: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    case (op_q)
                        OP_ADD: begin
                            bus.result  <= add_res;
                            bus.err_ovf <= add_ovf;
                        end
                        OP_SUB: begin
                            bus.result  <= sub_res;
                            bus.err_ovf <= sub_ovf;
                        end
                        OP_DIV: begin
                            bus.result   <= '0;
                            bus.err_div0 <= 1'b1;
                        end
                        default: bus.err_op <= 1'b1;
                    endcase
                end
                S_ITER: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                S_FIX: begin
                    bus.busy    <= 1'b0;
                    bus.done    <= 1'b1;
                    bus.result  <= fix_res;
                    bus.err_ovf <= fix_ovf;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_alu_seq.sv
// Self-checking bench for calc_alu_seq: directed vectors, random traffic against
// an integer-arithmetic reference, handshake and mid-operation reset scenarios.
module tb_calc_alu_seq;
    import calc_pkg::*;

    localparam int W    = 10;
    localparam int MAXP = (1 << (W - 1)) - 1;
    localparam int MINN = -(1 << (W - 1));

    typedef struct {
        logic [W-1:0] res;
        logic         d0;
        logic         ov;
        logic         eo;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [W-1:0] prev_res = '0;

    calc_alu_seq_if #(.WIDTH(W)) bus ();

    calc_alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #10 clk = ~clk;

    // Reference: plain integer arithmetic on the signed operand values.
    function automatic exp_t model(input int o, input int av, input int bv, input logic [W-1:0] prev);
        exp_t   e;
        longint r;
        e.res = prev; e.d0 = 1'b0; e.ov = 1'b0; e.eo = 1'b0; e.lat = 1;
        r = 0;
        case (o)
            1: r = longint'(av) + bv;
            2: r = longint'(av) - bv;
            3: r = longint'(av) * bv;
            4: if (bv != 0) r = longint'(av) / bv;
            default: ;
        endcase
        if (o >= 1 && o <= 3 || (o == 4 && bv != 0)) begin
            e.res = W'(r);
            e.ov  = (r > MAXP) || (r < MINN);
            if (o >= 3) e.lat = W + 2;
        end else if (o == 4) begin
            e.res = '0;
            e.d0  = 1'b1;
        end else begin
            e.eo  = 1'b1;
        end
        return e;
    endfunction

    function automatic int rand_opnd();
        int sel;
        int edges[5];
        edges = '{MINN, -1, 0, 1, MAXP};
        sel = $urandom_range(0, 7);
        if (sel < 5 && $urandom_range(0, 3) == 0) return edges[sel];
        return int'($urandom_range(0, (1 << W) - 1)) + MINN;
    endfunction

    // Issue one request, scramble the inputs after acceptance, wait for done.
    task automatic run_op(input int o, input int av, input int bv, output exp_t got);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'(o); bus.a = av[W-1:0]; bus.b = bv[W-1:0];
        @(negedge clk);
        bus.start = 1'b0;
        bus.op = 4'($urandom_range(0, 15)); bus.a = W'($urandom); bus.b = W'($urandom);
        got.lat = 0;
        do begin
            @(negedge clk);
            got.lat++;
        end while (!bus.done && got.lat < 60);
        if (!bus.done) got.lat = -1;
        got.res = bus.result; got.d0 = bus.err_div0; got.ov = bus.err_ovf; got.eo = bus.err_op;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_tests++;
            if ({bus.busy, bus.done, bus.result, bus.err_div0, bus.err_ovf, bus.err_op} !== '0) begin
                n_fail++;
                $display("FAIL reset_state: busy=%b done=%b result=%0d errs=%b%b%b, want all zero",
                         bus.busy, bus.done, bus.result, bus.err_div0, bus.err_ovf, bus.err_op);
            end
        end
    endtask

    task automatic test_directed();
        int   t_op[10] = '{1, 2, 3, 3, 4, 4, 4, 0, 6, 15};
        int   t_a [10] = '{123, -500, -12, 25, -7, 511, -512, 3, 4, 5};
        int   t_b [10] = '{45, 100, 34, 25, 2, 0, -1, 3, 4, 5};
        exp_t e, got;
        for (int i = 0; i < 10; i++) begin
            e = model(t_op[i], t_a[i], t_b[i], prev_res);
            run_op(t_op[i], t_a[i], t_b[i], got);
            prev_res = e.res;
            n_tests++;
            if (got.lat !== e.lat) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: op=%0d got %0d cycles, want %0d", i, t_op[i], got.lat, e.lat);
            end
            n_tests++;
            if ({got.res, got.d0, got.ov, got.eo} !== {e.res, e.d0, e.ov, e.eo}) begin
                n_fail++;
                $display("FAIL directed_value[%0d]: op=%0d a=%0d b=%0d got res=%0d d0/ovf/op=%b%b%b, want res=%0d %b%b%b",
                         i, t_op[i], t_a[i], t_b[i], got.res, got.d0, got.ov, got.eo, e.res, e.d0, e.ov, e.eo);
            end
        end
    endtask

    task automatic test_random();
        int   o, av, bv, sel;
        exp_t e, got;
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            av  = rand_opnd();
            bv  = rand_opnd();
            if (sel < 8) o = sel / 2 + 1;
            else if (sel == 8) begin
                o = $urandom_range(5, 15);
                if ($urandom_range(0, 2) == 0) o = 0;
            end else begin
                o = 4; bv = 0;
            end
            e = model(o, av, bv, prev_res);
            run_op(o, av, bv, got);
            prev_res = e.res;
            n_tests++;
            if (got.lat !== e.lat || {got.res, got.d0, got.ov, got.eo} !== {e.res, e.d0, e.ov, e.eo}) begin
                n_fail++;
                $display("FAIL random[%0d]: op=%0d a=%0d b=%0d got lat=%0d res=%0d errs=%b%b%b, want lat=%0d res=%0d errs=%b%b%b",
                         i, o, av, bv, got.lat, got.res, got.d0, got.ov, got.eo, e.lat, e.res, e.d0, e.ov, e.eo);
            end
            @(negedge clk);
            n_tests++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse[%0d]: done=%b busy=%b after done cycle, want 0 0", i, bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_busy_ignore();
        exp_t e;
        int   lat;
        e = model(3, 37, -9, prev_res);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd3; bus.a = W'(37); bus.b = W'(-9);
        @(negedge clk);
        bus.op = 4'd1; bus.a = W'(1); bus.b = W'(1);   // start stays high while busy
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_rise: busy=%b after accepting edge, want 1", bus.busy);
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.done && lat < 60);
        bus.start = 1'b0;
        prev_res = e.res;
        n_tests++;
        if (lat !== e.lat || bus.result !== e.res || bus.err_ovf !== e.ov) begin
            n_fail++;
            $display("FAIL busy_ignore: got lat=%0d res=%0d ovf=%b, want lat=%0d res=%0d ovf=%b",
                     lat, bus.result, bus.err_ovf, e.lat, e.res, e.ov);
        end
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_not_queued: busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e1, e2;
        int   lat;
        e1 = model(4, -300, 7, prev_res);
        e2 = model(2, 200, -100, e1.res);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd4; bus.a = W'(-300); bus.b = W'(7);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.done && lat < 60);
        n_tests++;
        if (lat !== e1.lat || bus.result !== e1.res || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: got lat=%0d res=%0d busy=%b, want lat=%0d res=%0d busy=0",
                     lat, bus.result, bus.busy, e1.lat, e1.res);
        end
        bus.start = 1'b1; bus.op = 4'd2; bus.a = W'(200); bus.b = W'(-100);
        @(negedge clk);
        bus.start = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b done=%b, want 1 0", bus.busy, bus.done);
        end
        @(negedge clk);
        prev_res = e2.res;
        n_tests++;
        if (bus.done !== 1'b1 || bus.result !== e2.res || bus.err_ovf !== e2.ov) begin
            n_fail++;
            $display("FAIL b2b_second: done=%b res=%0d ovf=%b, want 1 %0d %b",
                     bus.done, bus.result, bus.err_ovf, e2.res, e2.ov);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, got;
        int   seen;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd3; bus.a = W'(25); bus.b = W'(25);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.busy, bus.done, bus.result, bus.err_div0, bus.err_ovf, bus.err_op} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b result=%0d errs=%b%b%b, want all zero",
                     bus.busy, bus.done, bus.result, bus.err_div0, bus.err_ovf, bus.err_op);
        end
        @(negedge clk);
        rst = 1'b0;
        prev_res = '0;
        seen = 0;
        repeat (16) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_abort: done/busy seen in %0d cycles after reset, want 0", seen);
        end
        e = model(3, -12, 34, prev_res);
        run_op(3, -12, 34, got);
        prev_res = e.res;
        n_tests++;
        if (got.lat !== e.lat || got.res !== e.res || got.ov !== e.ov) begin
            n_fail++;
            $display("FAIL reset_recover: got lat=%0d res=%0d ovf=%b, want lat=%0d res=%0d ovf=%b",
                     got.lat, got.res, got.ov, e.lat, e.res, e.ov);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
